ram_dump_master: RTL and testbench
==================================

Name: ram_dump_master

Overview:
- Bus initiator that reads a contiguous byte region from the 8-bit data RAM and streams it out on a valid/ready byte interface, e.g. to a UART transmitter for result dumps such as the Fibonacci result at 0x0101.
- Drives the RAM's Address/WE/WriteDataBus and consumes ReadDataBus. It never writes.
- Arbitrates for the RAM port against the CPU with a req/gnt pair.

Parameters:
- ADDR_W, 16, RAM address width; matches the CPU address bus.
- DATA_W, 8, RAM data width and stream byte width.
- LEN_W, 16, width of the transfer length field.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first RAM address, latched on accepted start.
- length  in  LEN_W  number of bytes, latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- bus_req  out  1  request for the RAM port.
- bus_gnt  in  1  port granted; Address is valid to the RAM only while high.
- Address  out  ADDR_W  RAM address.
- WE  out  1  RAM write enable; constant 0.
- WriteDataBus  out  DATA_W  constant 0.
- ReadDataBus  in  DATA_W  combinational RAM read data.
- out_data  out  DATA_W  stream byte (registered).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the sink.

Behaviour:
- Reset (async, immediate): state IDLE. busy, done, bus_req, out_valid = 0; Address, out_data = 0; internal counters = 0. WE and WriteDataBus are always 0.
- State machine states: IDLE, REQ, FETCH, SEND, [CSUM], FIN.
- IDLE:
  - start=1 and length!=0: latch base_addr into Address, load remaining counter with length; busy=1, bus_req=1; go to REQ.
  - start=1 and length==0: busy=1 for one cycle, go to FIN. No bytes are emitted.
  - start=0: stay in IDLE.
- REQ: hold bus_req=1. When bus_gnt=1, go to FETCH.
- FETCH: Address is stable and gnt is held. On this posedge, capture ReadDataBus into out_data, set out_valid=1, and go to SEND.
- SEND:
  - out_valid holds and out_data is stable until out_valid&&out_ready.
  - On handshake, out_valid=0 and remaining decrements.
  - If remaining was 1: go to CSUM (feature on) or FIN (feature off).
  - Otherwise: Address <= Address+1, wrapping mod 2^ADDR_W (0xFFFF -> 0x0000), and go to FETCH.
- bus_gnt deasserted in FETCH: the capture is suppressed, and the block returns to REQ with Address unchanged.
- bus_gnt deasserted in SEND: it is ignored, because the byte is already registered. The next FETCH waits in REQ until gnt returns.
- bus_req: high in REQ, FETCH and SEND; low in IDLE and FIN. It is dropped for the cycle after the last handshake.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE. busy is low in the same cycle that done is high.
- start while busy is ignored; it is neither queued nor an error.
- Throughput: at most 1 byte per 2 clocks with constant gnt and ready. Latency from start to first out_valid is 3 clocks with immediate gnt.
- Reset mid-transfer aborts with no done pulse; any partial stream is lost.

Optional Feature:
- Macro: RAM_DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all emitted data bytes is kept; it is cleared on accepted start.
  - After the last data byte handshake, state CSUM presents out_data = two's complement of the sum, so that data+checksum ≡ 0 mod 256. out_valid=1 and bus_req=0.
  - On handshake, go to FIN.
  - length==0 emits no checksum.
- Undefined: no CSUM state and no accumulator. The last data handshake goes directly to FIN.

Decomposition:
- ram_dump_pkg contains:
  - state enum type, 3 bits;
  - localparams ADDR_W_DEF=16, DATA_W_DEF=8, LEN_W_DEF=16;
  - RESULT_ADDR=16'h0101.
- Single module. No sub-module is warranted; the checksum accumulator is a few lines inside the `ifdef.

Test Plan:
- RAM preloaded 0x0100..0x0103 = 0x01,0x02,0x03,0x05; start base=0x0100 len=4; gnt=1, ready=1 -> stream 01,02,03,05. done pulses once and busy falls with it. With the checksum macro, a 5th byte 0xF5 follows.
- Same transfer with out_ready toggling 1-0-0-1 -> each out_data held stable while valid&&!ready. Bytes are not duplicated or skipped; remaining only decrements on handshakes.
- bus_gnt held 0 for 5 cycles after start, then dropped during the 2nd FETCH -> no out_valid before the grant. The 2nd byte is refetched from the same address after the grant returns.
- base=0xFFFF, len=2, RAM model of 64K bytes -> bytes from 0xFFFF then 0x0000. Address wraps with no X values.
- len=0 start -> done pulse 2 clocks after start, out_valid never asserted, bus_req never asserted.
- rst_n asserted low mid-SEND (len=8, after 3 bytes) -> out_valid, bus_req and busy drop asynchronously with no done pulse. A subsequent start re-runs cleanly from the new base.

Source files
------------

// File: rtl/ram_dump_pkg.sv
// ram_dump_pkg: state encoding and default widths shared by the RAM dump master.
package ram_dump_pkg;
  typedef enum logic [2:0] {IDLE, REQ, FETCH, SEND, CSUM, FIN} state_e;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF = 16;
  localparam logic [15:0] RESULT_ADDR = 16'h0101;
endpackage

// File: rtl/ram_dump_master.sv
// ram_dump_master: reads a RAM byte region over an arbitrated port and streams it on valid/ready.
// Define RAM_DUMP_CHECKSUM_EN to append a two's-complement checksum byte after the data.
module ram_dump_master
  import ram_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] Address,
  output logic              WE,
  output logic [DATA_W-1:0] WriteDataBus,
  input  logic [DATA_W-1:0] ReadDataBus,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    data_d = data_q;
    valid_d = valid_q;
    busy_d = busy_q;
    done_d = 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
    sum_d = sum_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        busy_d = 1'b1;
        addr_d = base_addr;
        rem_d = length;
        state_d = (length != '0) ? REQ : FIN;
`ifdef RAM_DUMP_CHECKSUM_EN
        sum_d = '0;
`endif
      end
      REQ: if (bus_gnt) state_d = FETCH;
      // Losing the grant here drops the capture; the same address is refetched later.
      FETCH: if (bus_gnt) begin
        data_d = ReadDataBus;
        valid_d = 1'b1;
        state_d = SEND;
      end else state_d = REQ;
      SEND: if (out_ready) begin
        valid_d = 1'b0;
        rem_d = rem_q - LEN_W'(1);
`ifdef RAM_DUMP_CHECKSUM_EN
        sum_d = sum_q + data_q;
`endif
        if (rem_q == LEN_W'(1)) begin
`ifdef RAM_DUMP_CHECKSUM_EN
          data_d = -sum_d;
          valid_d = 1'b1;
          state_d = CSUM;
`else
          state_d = FIN;
`endif
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
`ifdef RAM_DUMP_CHECKSUM_EN
      CSUM: if (out_ready) begin
        valid_d = 1'b0;
        state_d = FIN;
      end
`endif
      FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
  assign bus_req = (state_q == REQ) || (state_q == FETCH) || (state_q == SEND);
  assign Address = addr_q;
  assign WE = 1'b0;
  assign WriteDataBus = '0;
  assign out_data = data_q;
  assign out_valid = valid_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_ram_dump_master.sv
// tb_ram_dump_master: directed bench for ram_dump_master with a 64K RAM model.
module tb_ram_dump_master;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, bus_req, bus_gnt, WE, out_valid, out_ready;
  logic [15:0] base_addr, length, Address;
  logic [7:0] WriteDataBus, ReadDataBus, out_data;
  logic [7:0] mem [0:65535];
  int n_cmp = 0, n_err = 0;
  logic [7:0] got_q[$];
  int first_v, first_done, n_done, busy_bad, stable_bad, stall_n, req_n, x_bad;
  logic busy0;

  ram_dump_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt), .Address(Address),
    .WE(WE), .WriteDataBus(WriteDataBus), .ReadDataBus(ReadDataBus),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  assign ReadDataBus = mem[Address];

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] l);
    base_addr = b;
    length = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs a fixed window; c=0 is the cycle right after start was sampled.
  task automatic collect(input int max_cyc, input logic [3:0] rdy, input int g_until, input int g_drop);
    logic pv;
    logic [7:0] pd;
    got_q.delete();
    first_v = -1; first_done = -1; n_done = 0; busy_bad = 0; stable_bad = 0;
    stall_n = 0; req_n = 0; x_bad = 0; busy0 = 1'b0; pv = 1'b0; pd = '0;
    for (int c = 0; c < max_cyc; c++) begin
      out_ready = rdy[c % 4];
      bus_gnt = (c >= g_until) && (c != g_drop);
      if (c == 0) busy0 = busy;
      if ($isunknown(Address) || $isunknown(out_data)) x_bad++;
      if (bus_req) req_n++;
      if (pv && (!out_valid || out_data !== pd)) stable_bad++;
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (out_valid && !out_ready) stall_n++;
      pv = out_valid && !out_ready;
      pd = out_data;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = c;
        if (busy) busy_bad++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    bus_gnt = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] act [8];
    string nm [8] = '{"busy", "done", "bus_req", "out_valid", "Address", "out_data", "WE", "WriteDataBus"};
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus_gnt = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    act = '{16'(busy), 16'(done), 16'(bus_req), 16'(out_valid), Address, 16'(out_data), 16'(WE), 16'(WriteDataBus)};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (act[i] !== 16'h0) begin n_err++; $display("FAIL reset_%s got %h exp 0", nm[i], act[i]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [3:0] rdy, input string tag);
    logic [7:0] exp[$] = '{8'h01, 8'h02, 8'h03, 8'h05};
    int exp_done = 10;
`ifdef RAM_DUMP_CHECKSUM_EN
    exp.push_back(8'hF5);
    exp_done = 11;
`endif
    pulse_start(16'h0100, 16'd4);
    collect(48, rdy, 0, -1);
    n_cmp++;
    if (got_q.size() !== exp.size()) begin n_err++; $display("FAIL %s_count got %0d exp %0d", tag, got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp[i]) begin n_err++; $display("FAIL %s_byte%0d got %h exp %h", tag, i, got_q[i], exp[i]); end
    end
    n_cmp++;
    if (n_done !== 1) begin n_err++; $display("FAIL %s_done_count got %0d exp 1", tag, n_done); end
    n_cmp++;
    if (busy_bad !== 0) begin n_err++; $display("FAIL %s_busy_with_done got %0d exp 0", tag, busy_bad); end
    n_cmp++;
    if (stable_bad !== 0) begin n_err++; $display("FAIL %s_hold_stable got %0d exp 0", tag, stable_bad); end
    if (rdy == 4'hF) begin
      n_cmp++;
      if (first_v !== 2) begin n_err++; $display("FAIL %s_latency got %0d exp 2", tag, first_v); end
      n_cmp++;
      if (first_done !== exp_done) begin n_err++; $display("FAIL %s_done_cycle got %0d exp %0d", tag, first_done, exp_done); end
    end else begin
      n_cmp++;
      if (stall_n == 0) begin n_err++; $display("FAIL %s_stalls got %0d exp >0", tag, stall_n); end
    end
  endtask

  task automatic test_gnt();
    logic [7:0] exp[$] = '{8'h01, 8'h02, 8'h03, 8'h05};
    int exp_done = 17;
`ifdef RAM_DUMP_CHECKSUM_EN
    exp.push_back(8'hF5);
    exp_done = 18;
`endif
    bus_gnt = 1'b0;
    pulse_start(16'h0100, 16'd4);
    collect(48, 4'hF, 5, 8);
    n_cmp++;
    if (first_v !== 7) begin n_err++; $display("FAIL gnt_first_valid got %0d exp 7", first_v); end
    n_cmp++;
    if (got_q.size() !== exp.size()) begin n_err++; $display("FAIL gnt_count got %0d exp %0d", got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp[i]) begin n_err++; $display("FAIL gnt_byte%0d got %h exp %h", i, got_q[i], exp[i]); end
    end
    n_cmp++;
    if (first_done !== exp_done) begin n_err++; $display("FAIL gnt_done_cycle got %0d exp %0d", first_done, exp_done); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp[$] = '{8'hA5, 8'h5A};
`ifdef RAM_DUMP_CHECKSUM_EN
    exp.push_back(8'h01);
`endif
    pulse_start(16'hFFFF, 16'd2);
    collect(30, 4'hF, 0, -1);
    n_cmp++;
    if (got_q.size() !== exp.size()) begin n_err++; $display("FAIL wrap_count got %0d exp %0d", got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp[i]) begin n_err++; $display("FAIL wrap_byte%0d got %h exp %h", i, got_q[i], exp[i]); end
    end
    n_cmp++;
    if (Address !== 16'h0000) begin n_err++; $display("FAIL wrap_addr got %h exp 0000", Address); end
    n_cmp++;
    if (x_bad !== 0) begin n_err++; $display("FAIL wrap_xvals got %0d exp 0", x_bad); end
  endtask

  task automatic test_len0();
    pulse_start(16'h0100, 16'd0);
    collect(12, 4'hF, 0, -1);
    n_cmp++;
    if (busy0 !== 1'b1) begin n_err++; $display("FAIL len0_busy got %b exp 1", busy0); end
    n_cmp++;
    if (first_done !== 1) begin n_err++; $display("FAIL len0_done_cycle got %0d exp 1", first_done); end
    n_cmp++;
    if (n_done !== 1) begin n_err++; $display("FAIL len0_done_count got %0d exp 1", n_done); end
    n_cmp++;
    if (req_n !== 0) begin n_err++; $display("FAIL len0_bus_req got %0d exp 0", req_n); end
    n_cmp++;
    if (first_v !== -1) begin n_err++; $display("FAIL len0_valid got %0d exp -1", first_v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$] = '{8'h03, 8'h05};
    int n = 0, dn = 0;
`ifdef RAM_DUMP_CHECKSUM_EN
    exp.push_back(8'hF8);
`endif
    out_ready = 1'b1; bus_gnt = 1'b1;
    pulse_start(16'h0100, 16'd8);
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
    n_cmp++;
    if (!(out_valid === 1'b1 && out_data === 8'h05)) begin n_err++; $display("FAIL mid_4th_byte got v=%b d=%h exp v=1 d=05", out_valid, out_data); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, bus_req, busy} !== 3'b000) begin n_err++; $display("FAIL mid_async_drop got %b exp 000", {out_valid, bus_req, busy}); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      if (done) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin n_err++; $display("FAIL mid_no_done got %0d exp 0", dn); end
    out_ready = 1'b1;
    pulse_start(16'h0102, 16'd2);
    collect(30, 4'hF, 0, -1);
    n_cmp++;
    if (got_q.size() !== exp.size()) begin n_err++; $display("FAIL rerun_count got %0d exp %0d", got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp[i]) begin n_err++; $display("FAIL rerun_byte%0d got %h exp %h", i, got_q[i], exp[i]); end
    end
    n_cmp++;
    if (n_done !== 1) begin n_err++; $display("FAIL rerun_done_count got %0d exp 1", n_done); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h02; mem[16'h0102] = 8'h03; mem[16'h0103] = 8'h05;
    mem[16'h0104] = 8'h08; mem[16'h0105] = 8'h0D; mem[16'h0106] = 8'h15; mem[16'h0107] = 8'h22;
    mem[16'hFFFF] = 8'hA5; mem[16'h0000] = 8'h5A;
    test_reset();
    test_basic(4'hF, "basic");
    test_basic(4'b1001, "ready");
    test_gnt();
    test_wrap();
    test_len0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
